// File: rtl/ex.sv
// MIPS execute stage: single-cycle ALU, HI/LO registers and a 32-step restoring divider
// that holds the upstream pipeline through stallreq_o while it iterates.
module ex #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic [3:0]         aluop_i,
   input  logic [DATA_W-1:0]  reg1_i,
   input  logic [DATA_W-1:0]  reg2_i,
   input  logic [RADDR_W-1:0] wreg_addr_i,
   input  logic               wreg_enable_i,
   output logic [RADDR_W-1:0] wreg_addr_o,
   output logic               wreg_enable_o,
   output logic [DATA_W-1:0]  wdata_o,
   output logic               stallreq_o,
   output logic [DATA_W-1:0]  hi_o,
   output logic [DATA_W-1:0]  lo_o
);

   localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADDU = 4'd1,  OP_SUBU = 4'd2,  OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4,  OP_XOR  = 4'd5,  OP_NOR  = 4'd6,  OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8,  OP_SLL  = 4'd9,  OP_SRL  = 4'd10, OP_SRA  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t        state, state_next;
   logic [DATA_W-1:0] hi, lo;
   logic [DATA_W-1:0] rem, quot, dvsr;
   logic              sign_q, sign_r, div_valid;
   logic [4:0]        cnt;

   logic              is_div, is_signed, div_zero;
   logic [DATA_W-1:0] a_abs, b_abs;
   logic [DATA_W:0]   trial, diff;
   logic              ge;
   logic [DATA_W-1:0] rem_step, quot_step, q_fix, r_fix;
   logic [DATA_W-1:0] alu;

   assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
   assign is_signed = (aluop_i == OP_DIV);
   assign div_zero  = (reg2_i == '0);
   assign a_abs     = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
   assign b_abs     = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

   // Quotient register doubles as the dividend shift register: its MSB feeds the remainder.
   assign trial     = {rem, quot[DATA_W-1]};
   assign diff      = trial - {1'b0, dvsr};
   assign ge        = ~diff[DATA_W];
   assign rem_step  = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
   assign quot_step = {quot[DATA_W-2:0], ge};
   assign q_fix     = sign_q ? -quot : quot;
   assign r_fix     = sign_r ? -rem : rem;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      stallreq_o = 1'b0;
      case (state)
         IDLE: if (is_div) state_next = div_zero ? DONE : BUSY;
         BUSY: if (cnt == 5'd31) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (is_div && (state != DONE)) stallreq_o = 1'b1;
      if (flush_i) begin
         state_next = IDLE;
         stallreq_o = 1'b0;
      end
      if (rst) stallreq_o = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi        <= '0;
         lo        <= '0;
         rem       <= '0;
         quot      <= '0;
         dvsr      <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         div_valid <= 1'b0;
         cnt       <= '0;
      end else if (!flush_i) begin
         case (state)
            IDLE: if (is_div) begin
               div_valid <= ~div_zero;
               rem       <= '0;
               quot      <= a_abs;
               dvsr      <= b_abs;
               sign_q    <= is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
               sign_r    <= is_signed && reg1_i[DATA_W-1];
               cnt       <= '0;
            end
            BUSY: begin
               rem  <= rem_step;
               quot <= quot_step;
               cnt  <= cnt + 5'd1;
            end
            DONE: begin
               if (div_valid) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end
               div_valid <= 1'b0;
            end
            default: ;
         endcase
      end else begin
         div_valid <= 1'b0;
      end
   end

   always_comb begin
      alu = '0;
      case (aluop_i)
         OP_NOP:  alu = '0;
         OP_ADDU: alu = reg1_i + reg2_i;
         OP_SUBU: alu = reg1_i - reg2_i;
         OP_AND:  alu = reg1_i & reg2_i;
         OP_OR:   alu = reg1_i | reg2_i;
         OP_XOR:  alu = reg1_i ^ reg2_i;
         OP_NOR:  alu = ~(reg1_i | reg2_i);
         OP_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
         OP_SLTU: alu = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
         OP_SLL:  alu = reg2_i << reg1_i[4:0];
         OP_SRL:  alu = reg2_i >> reg1_i[4:0];
         OP_SRA:  alu = $signed(reg2_i) >>> reg1_i[4:0];
         OP_MFHI: alu = hi;
         OP_MFLO: alu = lo;
         default: alu = '0;
      endcase
   end

   always_comb begin
      wreg_addr_o   = wreg_addr_i;
      wreg_enable_o = wreg_enable_i && !is_div;
      wdata_o       = alu;
      if (rst || flush_i) begin
         wreg_addr_o   = '0;
         wreg_enable_o = 1'b0;
         wdata_o       = '0;
      end
   end

   assign hi_o = hi;
   assign lo_o = lo;

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the execute stage: the driver pushes model results per instruction,
// a negedge monitor pops one entry each cycle the stage is not stalling.
module tb_ex;

   logic        clk = 1'b0;
   logic        rst, flush_i;
   logic [3:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wreg_addr_i;
   logic        wreg_enable_i;
   logic [4:0]  wreg_addr_o;
   logic        wreg_enable_o;
   logic [31:0] wdata_o, hi_o, lo_o;
   logic        stallreq_o;

   ex #(.DATA_W(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wreg_addr_i(wreg_addr_i),
      .wreg_enable_i(wreg_enable_i), .wreg_addr_o(wreg_addr_o),
      .wreg_enable_o(wreg_enable_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wdata;
      logic [4:0]  addr;
      logic        en;
      int unsigned stalls;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned id;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   bit          active = 1'b0;
   int unsigned stall_cnt = 0;
   int unsigned next_id = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic void chk(input string nm, input int unsigned id,
                               input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s instr#%0d: got %h expected %h", nm, id, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (active) begin
         if (stallreq_o) stall_cnt++;
         else begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: got output with no expected entry, expected an entry");
            end else begin
               mon_e = sb.pop_front();
               chk("wdata", mon_e.id, wdata_o, mon_e.wdata);
               chk("addr", mon_e.id, {27'b0, wreg_addr_o}, {27'b0, mon_e.addr});
               chk("en", mon_e.id, {31'b0, wreg_enable_o}, {31'b0, mon_e.en});
               chk("stalls", mon_e.id, 32'(stall_cnt), 32'(mon_e.stalls));
               chk("hi", mon_e.id, hi_o, mon_e.hi);
               chk("lo", mon_e.id, lo_o, mon_e.lo);
            end
            stall_cnt = 0;
         end
      end
   end

   task automatic wait_accept();
      int unsigned n = 0;
      forever begin
         @(negedge clk);
         if (!stallreq_o) break;
         n++;
         if (n > 100) begin
            total++;
            bad++;
            $display("FAIL timeout: stall still high after %0d cycles, expected release", n);
            break;
         end
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1 after the instruction is accepted.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic en);
      exp_t   e;
      longint sa, sd, q, r;
      e.id     = next_id++;
      e.hi     = m_hi;
      e.lo     = m_lo;
      e.addr   = addr;
      e.en     = en && !(op == 4'd12 || op == 4'd13);
      e.stalls = 0;
      e.wdata  = '0;
      case (op)
         4'd1:  e.wdata = a + b;
         4'd2:  e.wdata = a - b;
         4'd3:  e.wdata = a & b;
         4'd4:  e.wdata = a | b;
         4'd5:  e.wdata = a ^ b;
         4'd6:  e.wdata = ~(a | b);
         4'd7:  e.wdata = {31'b0, ($signed(a) < $signed(b))};
         4'd8:  e.wdata = {31'b0, (a < b)};
         4'd9:  e.wdata = b << a[4:0];
         4'd10: e.wdata = b >> a[4:0];
         4'd11: e.wdata = 32'($signed(b) >>> a[4:0]);
         4'd12, 4'd13: begin
            if (b == 32'd0) e.stalls = 1;
            else begin
               e.stalls = 33;
               if (op == 4'd12) begin
                  sa = longint'($signed(a));
                  sd = longint'($signed(b));
               end else begin
                  sa = longint'(a);
                  sd = longint'(b);
               end
               q = sa / sd;
               r = sa % sd;
               m_lo = q[31:0];
               m_hi = r[31:0];
            end
         end
         4'd14: e.wdata = m_hi;
         4'd15: e.wdata = m_lo;
         default: e.wdata = '0;
      endcase
      rst = 1'b0;
      flush_i = 1'b0;
      aluop_i = op;
      reg1_i = a;
      reg2_i = b;
      wreg_addr_i = addr;
      wreg_enable_i = en;
      sb.push_back(e);
      active = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
   endtask

   // Start a divide, then kill it with flush (use_rst=0) or reset after n stall cycles.
   task automatic abort_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned n, input bit use_rst);
      exp_t e;
      e.id = next_id++;
      e.hi = m_hi;
      e.lo = m_lo;
      e.addr = '0;
      e.en = 1'b0;
      e.wdata = '0;
      e.stalls = n;
      rst = 1'b0;
      flush_i = 1'b0;
      aluop_i = op;
      reg1_i = a;
      reg2_i = b;
      wreg_addr_i = 5'd9;
      wreg_enable_i = 1'b1;
      sb.push_back(e);
      active = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else flush_i = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush_i = 1'b0;
      if (use_rst) begin
         m_hi = '0;
         m_lo = '0;
      end
   endtask

   initial begin
      #1000000;
      total++;
      bad++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      exp_t        e0;
      logic [3:0]  op;
      logic [31:0] a, b;
      rst = 1'b1;
      flush_i = 1'b0;
      aluop_i = 4'd1;
      reg1_i = 32'h1234;
      reg2_i = 32'h5678;
      wreg_addr_i = 5'd7;
      wreg_enable_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      e0.id = next_id++;
      e0.wdata = '0;
      e0.addr = '0;
      e0.en = 1'b0;
      e0.stalls = 0;
      e0.hi = '0;
      e0.lo = '0;
      sb.push_back(e0);
      active = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;

      issue(4'd1, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
      issue(4'd7, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
      issue(4'd8, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
      issue(4'd11, 32'd4, 32'h80000000, 5'd6, 1'b1);
      issue(4'd12, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1);
      issue(4'd15, 32'd0, 32'd0, 5'd8, 1'b1);
      issue(4'd14, 32'd0, 32'd0, 5'd8, 1'b1);
      issue(4'd13, 32'h2211, 32'h100, 5'd2, 1'b1);
      issue(4'd13, 32'd100, 32'd0, 5'd2, 1'b1);
      issue(4'd14, 32'd0, 32'd0, 5'd10, 1'b1);
      issue(4'd15, 32'd0, 32'd0, 5'd11, 1'b0);
      issue(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd1, 1'b1);
      issue(4'd15, 32'd0, 32'd0, 5'd12, 1'b1);
      issue(4'd14, 32'd0, 32'd0, 5'd12, 1'b1);
      abort_div(4'd13, 32'd1000, 32'd7, 11, 1'b0);
      issue(4'd14, 32'd0, 32'd0, 5'd13, 1'b1);
      issue(4'd13, 32'd1000, 32'd7, 5'd13, 1'b1);
      issue(4'd15, 32'd0, 32'd0, 5'd14, 1'b1);
      issue(4'd14, 32'd0, 32'd0, 5'd14, 1'b1);
      abort_div(4'd13, 32'd1000, 32'd7, 6, 1'b1);
      issue(4'd14, 32'd0, 32'd0, 5'd15, 1'b1);
      issue(4'd15, 32'd0, 32'd0, 5'd15, 1'b1);

      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
         if ((op == 4'd12 || op == 4'd13) && $urandom_range(0, 7) == 0) b = '0;
         issue(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end

      active = 1'b0;
      aluop_i = 4'd0;
      repeat (2) @(posedge clk);
      chk("sb_drain", next_id, 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
